// File: rtl/rd_port_arbiter.sv
// -----------------------------------------------------------------------------
// rd_port_arbiter
//
// Shares one memory-controller read port between NREQ read requesters
// (data, weight and auxiliary DMA read channels). One requester owns the
// port at a time. The owner's burst command is issued, BURST_LEN words are
// popped from the read-data FIFO and each word is strobed back to the owner.
// The next owner is chosen round-robin, starting after the previous winner.
//
// Ports
//   clk           clock, every register updates on the rising edge
//   rst           synchronous reset, active low (0 = reset)
//   req_en        per-requester read request (level, held until req_done)
//   req_addr      per-requester burst start address, packed NREQ x ADDR_W
//   req_data      returned word, shared by all requesters
//   req_we        one-hot strobe, req_data belongs to requester i
//   req_done      one-cycle pulse, burst for requester i complete
//   grant         one-hot current owner, 0 when idle
//   busy          high whenever the FSM is not in IDLE
//   mem_cmd_en    burst command strobe
//   mem_cmd_addr  burst start address of the current owner
//   mem_cmd_bl    burst length minus one (constant)
//   mem_cmd_full  command FIFO full
//   mem_rd_en     pop the read-data FIFO
//   mem_rd_data   read-data FIFO head (first-word-fall-through)
//   mem_rd_empty  read-data FIFO empty
//   fsm_state     debug view of the arbiter FSM (0 IDLE, 1 CMD, 2 READ, 3 DONE)
//
// Handshakes with the memory controller: a transfer happens on a rising
// edge where the sender's valid is high and the receiver is ready. For the
// command path valid is mem_cmd_en and ready is ~mem_cmd_full; mem_cmd_en is
// only raised while ready, so every cycle it is high is an accepted command.
// For the read-data path valid is ~mem_rd_empty and ready is mem_rd_en; the
// arbiter only raises mem_rd_en while the FIFO is non-empty, so every cycle
// it is high is exactly one popped word.
// -----------------------------------------------------------------------------
module rd_port_arbiter #(
  parameter int NREQ      = 4,
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 16,
  parameter int BURST_LEN = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req_en,
  input  logic [NREQ*ADDR_W-1:0]   req_addr,
  output logic [DATA_W-1:0]        req_data,
  output logic [NREQ-1:0]          req_we,
  output logic [NREQ-1:0]          req_done,
  output logic [NREQ-1:0]          grant,
  output logic                     busy,
  output logic                     mem_cmd_en,
  output logic [ADDR_W-1:0]        mem_cmd_addr,
  output logic [5:0]               mem_cmd_bl,
  input  logic                     mem_cmd_full,
  output logic                     mem_rd_en,
  input  logic [DATA_W-1:0]        mem_rd_data,
  input  logic                     mem_rd_empty,
  output logic [1:0]               fsm_state
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NREQ - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMD  = 2'd1,
    READ = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t               state_q;
  state_t               state_d;

  logic [PTR_W-1:0]     ptr_q;       // first index scanned at next arbitration
  logic [PTR_W-1:0]     winner_q;    // index of current owner
  logic [CNT_W-1:0]     cnt_q;       // words popped in the current burst
  logic [NREQ-1:0]      grant_q;
  logic [ADDR_W-1:0]    cmd_addr_q;
  logic [DATA_W-1:0]    req_data_q;
  logic [NREQ-1:0]      req_we_q;
  logic [NREQ-1:0]      req_done_q;

  logic                 pick_valid;
  logic [PTR_W-1:0]     pick_idx;
  logic [PTR_W-1:0]     scan_idx;
  logic [PTR_W-1:0]     ptr_next;
  logic [ADDR_W-1:0]    addr_arr [NREQ];

  // Unpack the flat address bus so the winner's address is a plain index.
  for (genvar g = 0; g < NREQ; g++) begin : g_addr
    assign addr_arr[g] = req_addr[g*ADDR_W +: ADDR_W];
  end

  // Round-robin pick: scan ptr, ptr+1, ... (mod NREQ) and take the first
  // requester found. Because ptr moves past the last winner, a requester
  // that re-asserts immediately is scanned last.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    scan_idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = PTR_W'((int'(ptr_q) + k) % NREQ);
      if (!pick_valid && req_en[scan_idx]) begin
        pick_valid = 1'b1;
        pick_idx   = scan_idx;
      end
    end
  end

  assign ptr_next = (winner_q == LAST_REQ) ? '0 : winner_q + 1'b1;

  // FSM state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state and the two combinational memory strobes
  always_comb begin
    state_d    = state_q;
    mem_cmd_en = 1'b0;
    mem_rd_en  = 1'b0;
    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          state_d = CMD;
        end
      end
      CMD: begin
        if (!mem_cmd_full) begin
          mem_cmd_en = 1'b1;
          state_d    = READ;
        end
      end
      READ: begin
        if (!mem_rd_empty) begin
          mem_rd_en = 1'b1;
          if (cnt_q == LAST_CNT) begin
            state_d = DONE;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: ownership, command address, word counter and return strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q      <= '0;
      winner_q   <= '0;
      cnt_q      <= '0;
      grant_q    <= '0;
      cmd_addr_q <= '0;
      req_data_q <= '0;
      req_we_q   <= '0;
      req_done_q <= '0;
    end else begin
      // Strobes are single-cycle unless re-armed below.
      req_we_q   <= '0;
      req_done_q <= '0;
      case (state_q)
        IDLE: begin
          if (pick_valid) begin
            grant_q    <= NREQ'(1) << pick_idx;
            winner_q   <= pick_idx;
            cmd_addr_q <= addr_arr[pick_idx];
          end
        end
        READ: begin
          // Word reaches the requester one cycle after its pop.
          if (mem_rd_en) begin
            req_data_q <= mem_rd_data;
            req_we_q   <= grant_q;
            cnt_q      <= (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
          end
        end
        DONE: begin
          // req_done lands on the cycle the last req_we drops.
          req_done_q <= grant_q;
          grant_q    <= '0;
          ptr_q      <= ptr_next;
        end
        default: begin
        end
      endcase
    end
  end

  assign req_data     = req_data_q;
  assign req_we       = req_we_q;
  assign req_done     = req_done_q;
  assign grant        = grant_q;
  assign busy         = (state_q != IDLE);
  assign mem_cmd_addr = cmd_addr_q;
  assign mem_cmd_bl   = 6'(BURST_LEN - 1);
  assign fsm_state    = state_q;

endmodule

// File: tb/tb_rd_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rd_port_arbiter
//
// Bench for rd_port_arbiter. A small memory-controller model accepts burst
// commands and fills a first-word-fall-through read FIFO; expected words are
// queued per test and checked in order as the arbiter strobes them back.
// -----------------------------------------------------------------------------
module tb_rd_port_arbiter;

  localparam int NREQ      = 4;
  localparam int ADDR_W    = 30;
  localparam int DATA_W    = 16;
  localparam int BURST_LEN = 16;
  localparam int BUDGET    = 2000;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_CMD  = 2'd1;

  localparam logic [ADDR_W-1:0] A0 = 30'h01234A0;
  localparam logic [ADDR_W-1:0] A1 = 30'h02345B1;
  localparam logic [ADDR_W-1:0] A2 = 30'h03456C2;
  localparam logic [ADDR_W-1:0] A3 = 30'h04567D3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst;
  logic [NREQ-1:0]        req_en;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0]      req_data;
  logic [NREQ-1:0]        req_we;
  logic [NREQ-1:0]        req_done;
  logic [NREQ-1:0]        grant;
  logic                   busy;
  logic                   mem_cmd_en;
  logic [ADDR_W-1:0]      mem_cmd_addr;
  logic [5:0]             mem_cmd_bl;
  logic                   mem_cmd_full;
  logic                   mem_rd_en;
  logic [DATA_W-1:0]      mem_rd_data  = '0;
  logic                   mem_rd_empty = 1'b1;
  logic [1:0]             fsm_state;

  rd_port_arbiter #(
    .NREQ(NREQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_LEN(BURST_LEN)
  ) dut (
    .clk(clk), .rst(rst), .req_en(req_en), .req_addr(req_addr),
    .req_data(req_data), .req_we(req_we), .req_done(req_done),
    .grant(grant), .busy(busy), .mem_cmd_en(mem_cmd_en),
    .mem_cmd_addr(mem_cmd_addr), .mem_cmd_bl(mem_cmd_bl),
    .mem_cmd_full(mem_cmd_full), .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data), .mem_rd_empty(mem_rd_empty),
    .fsm_state(fsm_state)
  );

  // ---------------- scoreboard state ----------------
  int total = 0;
  int bad   = 0;
  logic [NREQ+DATA_W-1:0] exp_q[$];
  logic [NREQ+DATA_W-1:0] exp_e;
  int we_cnt[NREQ];
  int done_cnt[NREQ];
  logic [NREQ-1:0] grant_log[$];
  int gap_log[$];
  logic [NREQ-1:0] prev_grant = '0;
  int last_done_cyc = 0;

  // ---------------- memory-controller model ----------------
  logic [DATA_W-1:0] fifo_q[$];
  logic [ADDR_W-1:0] cmd_addr_log[$];
  int   cmd_cnt = 0;
  int   cyc = 0;
  logic auto_fill;
  logic stall_toggle;
  logic stall = 1'b0;

  function automatic logic [DATA_W-1:0] mk_word(input logic [ADDR_W-1:0] a, input int i);
    return {a[7:0], 8'(i + 1)};
  endfunction

  // Accepts commands and pops words on the edge where the strobe is high.
  always @(posedge clk) begin
    cyc++;
    if (!rst) begin
      fifo_q.delete();
    end else begin
      if (mem_rd_en && fifo_q.size() > 0) void'(fifo_q.pop_front());
      if (mem_cmd_en) begin
        cmd_cnt++;
        cmd_addr_log.push_back(mem_cmd_addr);
        if (auto_fill)
          for (int i = 0; i < BURST_LEN; i++) fifo_q.push_back(mk_word(mem_cmd_addr, i));
      end
    end
  end

  // FIFO outputs change only on the falling edge, away from DUT sampling.
  always @(negedge clk) begin
    stall        = stall_toggle ? ~stall : 1'b0;
    mem_rd_empty = (fifo_q.size() == 0) || stall;
    mem_rd_data  = (fifo_q.size() > 0) ? fifo_q[0] : '0;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish, required finish before 500us");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  // One cycle: wait for the falling edge, then check any returned word.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      if (req_we !== '0) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL word_unexpected: got we=%b data=%h, required no strobe", req_we, req_data);
        end else begin
          exp_e = exp_q.pop_front();
          if ({req_we, req_data} !== exp_e) begin
            bad++;
            $display("FAIL word: got we=%b data=%h, required we=%b data=%h",
                     req_we, req_data, exp_e[DATA_W +: NREQ], exp_e[DATA_W-1:0]);
          end
        end
        for (int r = 0; r < NREQ; r++) if (req_we[r]) we_cnt[r]++;
      end
      for (int r = 0; r < NREQ; r++) if (req_done[r]) done_cnt[r]++;
      if (req_done !== '0) last_done_cyc = cyc;
      if (grant !== '0 && prev_grant === '0) begin
        grant_log.push_back(grant);
        gap_log.push_back(cyc - last_done_cyc);
      end
    end
    prev_grant = grant;
  endtask

  task automatic clear_stats();
    for (int r = 0; r < NREQ; r++) begin
      we_cnt[r]   = 0;
      done_cnt[r] = 0;
    end
    grant_log.delete();
    gap_log.delete();
    cmd_addr_log.delete();
    cmd_cnt = 0;
  endtask

  task automatic set_addr(input int r, input logic [ADDR_W-1:0] a);
    req_addr[r*ADDR_W +: ADDR_W] = a;
  endtask

  task automatic expect_words(input int r, input logic [ADDR_W-1:0] a, input int n);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << r;
    for (int i = 0; i < n; i++) exp_q.push_back({oh, mk_word(a, i)});
  endtask

  task automatic wait_quiet(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < BUDGET) begin
      tick();
      n++;
    end
    total++;
    if (exp_q.size() != 0 || busy) begin
      bad++;
      $display("FAIL %s_quiet: got pending=%0d busy=%b, required pending=0 busy=0", name, exp_q.size(), busy);
    end
  endtask

  // Hold pattern until n more grants appear, then drop it and drain.
  task automatic run_grants(input logic [NREQ-1:0] pattern, input int n, input string name);
    int base;
    int k;
    base   = grant_log.size();
    req_en = pattern;
    k = 0;
    while (grant_log.size() < base + n && k < BUDGET) begin
      tick();
      k++;
    end
    req_en = '0;
    total++;
    if (grant_log.size() < base + n) begin
      bad++;
      $display("FAIL %s_grants: got %0d grants, required %0d", name, grant_log.size() - base, n);
    end
    wait_quiet(name);
  endtask

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h", name, got, want);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    req_en = '1;
    repeat (3) tick();
    chk("reset_grant", 64'(grant), 64'h0);
    chk("reset_strobes", 64'({req_we, req_done}), 64'h0);
    chk("reset_req_data", 64'(req_data), 64'h0);
    chk("reset_cmd", 64'({mem_cmd_en, mem_cmd_addr}), 64'h0);
    chk("reset_rd_en", 64'(mem_rd_en), 64'h0);
    chk("reset_busy", 64'(busy), 64'h0);
    chk("reset_state", 64'(fsm_state), 64'(S_IDLE));
    rst = 1'b1;
    tick();
    chk("reset_first_grant", 64'(grant), 64'h1);
    // Abandon this burst before any word is popped.
    rst = 1'b0;
    req_en = '0;
    tick();
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_round_robin();
    logic [NREQ-1:0] order [5];
    order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    clear_stats();
    expect_words(0, A0, BURST_LEN);
    expect_words(1, A1, BURST_LEN);
    expect_words(2, A2, BURST_LEN);
    expect_words(3, A3, BURST_LEN);
    expect_words(0, A0, BURST_LEN);
    run_grants(4'b1111, 5, "rr_all");
    for (int k = 0; k < 5; k++)
      if (grant_log.size() > k) chk($sformatf("rr_order_%0d", k), 64'(grant_log[k]), 64'(order[k]));
    for (int k = 1; k < 5; k++)
      if (gap_log.size() > k) chk($sformatf("rr_turnaround_%0d", k), 64'(gap_log[k]), 64'd1);
    if (cmd_addr_log.size() > 3) chk("rr_cmd_addr3", 64'(cmd_addr_log[3]), 64'(A3));
    chk("rr_done0", 64'(done_cnt[0]), 64'd2);
    chk("rr_done3", 64'(done_cnt[3]), 64'd1);
    // Move the pointer to 2, then requesters 0 and 1: 0 must win first.
    clear_stats();
    expect_words(1, A1, BURST_LEN);
    run_grants(4'b0010, 1, "rr_setup");
    expect_words(0, A0, BURST_LEN);
    expect_words(1, A1, BURST_LEN);
    run_grants(4'b0011, 2, "rr_wrap");
    if (grant_log.size() > 2) begin
      chk("rr_wrap_first", 64'(grant_log[1]), 64'b0001);
      chk("rr_wrap_second", 64'(grant_log[2]), 64'b0010);
    end
  endtask

  task automatic test_single_burst();
    logic [NREQ-1:0] oh;
    oh = 4'b0100;
    clear_stats();
    auto_fill = 1'b0;
    for (int i = 0; i < BURST_LEN; i++) begin
      fifo_q.push_back(16'(i + 1));
      exp_q.push_back({oh, 16'(i + 1)});
    end
    set_addr(2, 30'h100);
    run_grants(4'b0100, 1, "single");
    auto_fill = 1'b1;
    chk("single_cmd_count", 64'(cmd_cnt), 64'd1);
    if (cmd_addr_log.size() > 0) chk("single_cmd_addr", 64'(cmd_addr_log[0]), 64'h100);
    chk("single_cmd_bl", 64'(mem_cmd_bl), 64'd15);
    chk("single_we_count", 64'(we_cnt[2]), 64'd16);
    chk("single_done", 64'(done_cnt[2]), 64'd1);
    chk("single_grant_idle", 64'(grant), 64'h0);
    set_addr(2, A2);
  endtask

  task automatic test_backpressure();
    int k;
    clear_stats();
    mem_cmd_full = 1'b1;
    stall_toggle = 1'b1;
    expect_words(3, A3, BURST_LEN);
    req_en = 4'b1000;
    k = 0;
    while (grant_log.size() < 1 && k < BUDGET) begin
      tick();
      k++;
    end
    chk("bp_grant", 64'(grant), 64'b1000);
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp_cmd_low_%0d", i), 64'(mem_cmd_en), 64'd0);
      chk($sformatf("bp_addr_hold_%0d", i), 64'(mem_cmd_addr), 64'(A3));
      tick();
    end
    mem_cmd_full = 1'b0;
    #1;
    chk("bp_cmd_release", 64'({mem_cmd_en, fsm_state}), 64'({1'b1, S_CMD}));
    req_en = '0;
    wait_quiet("bp");
    stall_toggle = 1'b0;
    chk("bp_cmd_count", 64'(cmd_cnt), 64'd1);
    chk("bp_we_count", 64'(we_cnt[3]), 64'd16);
    chk("bp_done", 64'(done_cnt[3]), 64'd1);
  endtask

  task automatic test_drop_request();
    int k;
    clear_stats();
    expect_words(1, A1, BURST_LEN);
    req_en = 4'b0010;
    k = 0;
    while (we_cnt[1] < 4 && k < BUDGET) begin
      tick();
      k++;
    end
    req_en = '0;
    wait_quiet("drop");
    repeat (5) tick();
    chk("drop_we_count", 64'(we_cnt[1]), 64'd16);
    chk("drop_done", 64'(done_cnt[1]), 64'd1);
    chk("drop_no_regrant", 64'(grant_log.size()), 64'd1);
    chk("drop_grant_idle", 64'(grant), 64'h0);
  endtask

  task automatic test_reset_mid_burst();
    int k;
    clear_stats();
    expect_words(0, A0, 7);
    req_en = 4'b0001;
    k = 0;
    while (we_cnt[0] < 7 && k < BUDGET) begin
      tick();
      k++;
    end
    rst = 1'b0;
    req_en = '0;
    tick();
    chk("midrst_state", 64'(fsm_state), 64'(S_IDLE));
    chk("midrst_we", 64'(req_we), 64'h0);
    chk("midrst_grant", 64'(grant), 64'h0);
    chk("midrst_busy", 64'({busy, mem_rd_en}), 64'h0);
    chk("midrst_words", 64'(exp_q.size()), 64'd0);
    tick();
    rst = 1'b1;
    tick();
    // Pointer restarts at 0, so requester 1 beats 3; a full burst proves the
    // word counter restarted too.
    clear_stats();
    expect_words(1, A1, BURST_LEN);
    run_grants(4'b1010, 1, "post_rst");
    if (grant_log.size() > 0) chk("post_rst_grant", 64'(grant_log[0]), 64'b0010);
    chk("post_rst_we_count", 64'(we_cnt[1]), 64'd16);
    chk("post_rst_done", 64'(done_cnt[1]), 64'd1);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    rst          = 1'b0;
    req_en       = '0;
    req_addr     = '0;
    mem_cmd_full = 1'b0;
    auto_fill    = 1'b1;
    stall_toggle = 1'b0;
    set_addr(0, A0);
    set_addr(1, A1);
    set_addr(2, A2);
    set_addr(3, A3);
    clear_stats();

    test_reset();
    test_round_robin();
    test_single_burst();
    test_backpressure();
    test_drop_request();
    test_reset_mid_burst();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rd_port_arbiter.md
Name: rd_port_arbiter

Overview:
Round-robin arbiter that shares one memory-controller read port between NREQ engine read requesters (data, weight and auxiliary DMA read channels). It grants one requester at a time, issues one fixed-length read burst command, and streams the returned words back to the granted requester with a one-hot write strobe. It sits between the engine's per-port reads_en/addr outputs and the memory-controller user interface.

Parameters:
NREQ, 4, number of read requesters
ADDR_W, 30, burst start address width
DATA_W, 16, data word width
BURST_LEN, 16, words per burst (1..64)

Ports:
clk  in  1  clock, all logic on rising edge
rst  in  1  synchronous active-low reset (0 = reset)
req_en  in  NREQ  per-requester read request, level; held until req_done
req_addr  in  NREQ*ADDR_W  per-requester burst address; requester i uses bits [i*ADDR_W +: ADDR_W]
req_data  out  DATA_W  returned word, shared by all requesters
req_we  out  NREQ  one-hot strobe: req_data valid for requester i
req_done  out  NREQ  one-cycle pulse: burst for requester i complete
grant  out  NREQ  one-hot current owner; 0 when idle
busy  out  1  high in any state except IDLE
mem_cmd_en  out  1  burst command strobe
mem_cmd_addr  out  ADDR_W  burst start address
mem_cmd_bl  out  6  burst length minus 1 (constant BURST_LEN-1)
mem_cmd_full  in  1  command FIFO full
mem_rd_en  out  1  pop read-data FIFO
mem_rd_data  in  DATA_W  read-data FIFO head, first-word-fall-through
mem_rd_empty  in  1  read-data FIFO empty

Behaviour:
- Reset (rst=0 at clk edge): state IDLE, rr pointer 0, word counter 0, grant 0, req_we 0, req_done 0, req_data 0, mem_cmd_en 0, mem_cmd_addr 0, mem_rd_en 0, busy 0. Reset mid-burst abandons the burst without draining; the memory controller is reset in the same domain.
- States: IDLE, CMD, READ, DONE.
- IDLE: if any req_en bit set, select first set index scanning ptr, ptr+1, ... mod NREQ; register grant, latch req_addr of winner into mem_cmd_addr; go CMD next cycle. No req_en: stay.
- CMD: mem_cmd_en = 1 combinationally while state=CMD and mem_cmd_full=0; the cycle it is high is the command acceptance; go READ. mem_cmd_full=1: stay, mem_cmd_en=0, address held.
- READ: mem_rd_en = (state=READ) & ~mem_rd_empty, combinational. Each pop: req_data <= mem_rd_data, req_we <= grant (registered, 1-cycle latency from pop), counter++. Pop with counter==BURST_LEN-1: counter <= 0, go DONE. Non-pop cycles: req_we <= 0.
- DONE (one cycle): req_done <= grant (pulse visible the cycle after DONE entry, aligned with last req_we dropping); ptr <= (winner index + 1) mod NREQ; grant <= 0; go IDLE.
- Fairness: requester re-asserting immediately waits behind any other pending requester; with all NREQ requesting, grant order strictly rotates.
- req_en deasserted mid-burst: burst still completes and data still strobed (command already issued). req_addr changes after IDLE latch are ignored.
- mem_rd_empty toggling mid-burst: stalls only, no word lost or duplicated.
- Minimum turnaround between bursts: DONE + IDLE = 2 cycles after last pop.
- Counter width: ceil(log2(BURST_LEN)) bits, minimum 1.
- mem_rd_en never asserted outside READ; mem_cmd_en never asserted outside CMD.

Test Plan:
- Reset: hold rst=0 3 cycles with req_en=4'b1111 -> all outputs 0, busy=0; release -> grant=4'b0001 one cycle later.
- Single burst: req_en=4'b0100, addr2=30'h100, FIFO preloaded with 16 words 0x0001..0x0010 -> one mem_cmd_en pulse, mem_cmd_addr=30'h100, mem_cmd_bl=15, 16 req_we[2] pulses carrying 0x0001..0x0010 in order, one req_done[2] pulse, grant returns 0.
- Round-robin: req_en=4'b1111 held -> grant order 0,1,2,3,0; with ptr=2 and req_en=4'b0011 -> grant 0 then 1.
- Backpressure: mem_cmd_full=1 for 5 cycles in CMD -> mem_cmd_en low throughout, address stable, command issued cycle full drops; mem_rd_empty toggled every other cycle -> exactly 16 req_we, data order preserved.
- Drop request: requester 1 deasserts req_en after 4th word -> remaining 12 words delivered, req_done[1] pulses, no new grant to 1.
- Reset mid-burst: rst=0 after 7th word -> next cycle state IDLE, req_we=0, grant=0, counter 0.
